// File: rtl/agu_burst.sv
// Pipelined segment:offset address generation unit with registered valid/ready output
// and a string-burst mode that walks COUNT consecutive offsets by +/-STEP.
module agu_burst #(
    parameter int OFF_W     = 16,
    parameter int SEG_SHIFT = 4,
    parameter int ADDR_W    = OFF_W + SEG_SHIFT,
    parameter int CNT_W     = 8,
    parameter int STEP      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [OFF_W-1:0]  in_seg,
    input  logic [OFF_W-1:0]  in_ip,
    input  logic [OFF_W-1:0]  in_rel,
    input  logic [OFF_W-1:0]  in_reg1,
    input  logic [OFF_W-1:0]  in_reg2,
    input  logic [CNT_W-1:0]  in_count,
    input  logic              in_dir,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [OFF_W-1:0]  out_offset,
    output logic              out_last,
    output logic              out_wrap,
    output logic              out_carry
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // Output fields hold while out_valid && !out_ready.
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    localparam logic [OFF_W:0] STEP_V = (OFF_W+1)'(STEP);

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_remaining;
    logic [OFF_W-1:0]  r_seg;
    logic              r_dir;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [OFF_W-1:0]  r_offset;
    logic              r_last;
    logic              r_wrap;
    logic              r_carry;

    logic [OFF_W+1:0]  w_ip_x;
    logic [OFF_W+1:0]  w_rel_x;
    logic [OFF_W+1:0]  w_reg1_x;
    logic [OFF_W+1:0]  w_reg2_x;
    logic [OFF_W+1:0]  w_off_sum;
    logic [OFF_W-1:0]  w_new_off;
    logic              w_new_wrap;
    logic [ADDR_W:0]   w_new_phys;
    logic [OFF_W:0]    w_step_sum;
    logic [ADDR_W:0]   w_step_phys;
    logic [CNT_W-1:0]  w_cnt_eff;
    logic [CNT_W-1:0]  w_new_rem;
    logic              w_accept;
    logic              w_out_hs;

    function automatic logic [ADDR_W:0] phys(input logic [OFF_W-1:0] seg,
                                             input logic [OFF_W-1:0] off);
        logic [ADDR_W:0] s;
        s = '0;
        s[SEG_SHIFT +: OFF_W] = seg;
        return s + {{(ADDR_W+1-OFF_W){1'b0}}, off};
    endfunction

    assign w_ip_x   = {2'b00, in_ip};
    assign w_rel_x  = {2'b00, in_rel};
    assign w_reg1_x = {2'b00, in_reg1};
    assign w_reg2_x = {2'b00, in_reg2};

    always_comb begin
        w_off_sum = '0;
        case (in_mode)
            3'd0:    w_off_sum = w_ip_x;
            3'd1:    w_off_sum = w_rel_x;
            3'd2:    w_off_sum = w_reg1_x;
            3'd3:    w_off_sum = w_reg1_x + w_rel_x;
            3'd4:    w_off_sum = w_reg1_x + w_reg2_x;
            3'd5:    w_off_sum = w_reg1_x + w_reg2_x + w_rel_x;
            3'd6:    w_off_sum = w_ip_x + w_rel_x;
            default: w_off_sum = w_reg1_x;
        endcase
    end

    // Three-operand sum can carry by up to 2, so any upper bit means the offset wrapped.
    assign w_new_off  = w_off_sum[OFF_W-1:0];
    assign w_new_wrap = |w_off_sum[OFF_W+1:OFF_W];
    assign w_new_phys = phys(in_seg, w_new_off);

    // Borrow on decrement shows up in the top bit exactly like carry on increment.
    assign w_step_sum  = r_dir ? ({1'b0, r_offset} - STEP_V) : ({1'b0, r_offset} + STEP_V);
    assign w_step_phys = phys(r_seg, w_step_sum[OFF_W-1:0]);

    assign w_cnt_eff = (in_count == '0) ? CNT_W'(1) : in_count;
    assign w_new_rem = w_cnt_eff - CNT_W'(1);

    assign in_ready = !abort && (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_out_hs = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_seg       <= '0;
            r_dir       <= 1'b0;
            r_out_valid <= 1'b0;
            r_addr      <= '0;
            r_offset    <= '0;
            r_last      <= 1'b0;
            r_wrap      <= 1'b0;
            r_carry     <= 1'b0;
        end else if (abort) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
            r_remaining <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_seg       <= in_seg;
                r_dir       <= in_dir;
                r_offset    <= w_new_off;
                r_wrap      <= w_new_wrap;
                r_addr      <= w_new_phys[ADDR_W-1:0];
                r_carry     <= w_new_phys[ADDR_W];
                if (in_mode == 3'd7) begin
                    r_remaining <= w_new_rem;
                    r_last      <= (w_new_rem == '0);
                    r_state     <= (w_new_rem != '0) ? S_BURST : S_IDLE;
                end else begin
                    r_remaining <= '0;
                    r_last      <= 1'b1;
                end
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end else if (w_out_hs) begin
            if (r_last) begin
                r_out_valid <= 1'b0;
                r_state     <= S_IDLE;
            end else begin
                r_offset    <= w_step_sum[OFF_W-1:0];
                r_wrap      <= w_step_sum[OFF_W];
                r_addr      <= w_step_phys[ADDR_W-1:0];
                r_carry     <= w_step_phys[ADDR_W];
                r_remaining <= r_remaining - CNT_W'(1);
                r_last      <= (r_remaining == CNT_W'(1));
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_addr   = r_addr;
    assign out_offset = r_offset;
    assign out_last   = r_last;
    assign out_wrap   = r_wrap;
    assign out_carry  = r_carry;

endmodule

// File: tb/tb_agu_burst.sv
// Directed bench for agu_burst: stimulus pushes hand-computed beats into a queue,
// a negedge monitor pops and compares every accepted output beat.
module tb_agu_burst;

    localparam int EW = 20 + 16 + 3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_mode;
    logic [15:0] in_seg;
    logic [15:0] in_ip;
    logic [15:0] in_rel;
    logic [15:0] in_reg1;
    logic [15:0] in_reg2;
    logic [7:0]  in_count;
    logic        in_dir;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_addr;
    logic [15:0] out_offset;
    logic        out_last;
    logic        out_wrap;
    logic        out_carry;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    agu_burst dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_seg     (in_seg),
        .in_ip      (in_ip),
        .in_rel     (in_rel),
        .in_reg1    (in_reg1),
        .in_reg2    (in_reg2),
        .in_count   (in_count),
        .in_dir     (in_dir),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_offset (out_offset),
        .out_last   (out_last),
        .out_wrap   (out_wrap),
        .out_carry  (out_carry)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [19:0] addr, input logic [15:0] off,
                        input logic last, input logic wrap, input logic carry);
        exp_q.push_back({addr, off, last, wrap, carry});
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] mode, input logic [15:0] seg, input logic [15:0] ip,
                           input logic [15:0] rel, input logic [15:0] r1, input logic [15:0] r2,
                           input logic [7:0] cnt, input logic dir);
        in_mode  = mode;
        in_seg   = seg;
        in_ip    = ip;
        in_rel   = rel;
        in_reg1  = r1;
        in_reg2  = r2;
        in_count = cnt;
        in_dir   = dir;
        in_valid = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [2:0] mode, input logic [15:0] seg, input logic [15:0] ip,
                        input logic [15:0] rel, input logic [15:0] r1, input logic [15:0] r2,
                        input logic [7:0] cnt, input logic dir);
        bit done;
        int n;
        set_req(mode, seg, ip, rel, r1, r2, cnt, dir);
        done = 0;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            if (in_ready) done = 1;
            else step();
            n++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance");
        end else begin
            step();
        end
        in_valid = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n && out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got addr=0x%0h offset=0x%0h expected no output",
                         out_addr, out_offset);
            end else begin
                e = exp_q.pop_front();
                check("out_addr",   64'(out_addr),   64'(e[38:19]));
                check("out_offset", 64'(out_offset), 64'(e[18:3]));
                check("out_last",   64'(out_last),   64'(e[2]));
                check("out_wrap",   64'(out_wrap),   64'(e[1]));
                check("out_carry",  64'(out_carry),  64'(e[0]));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        set_req(3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 1'b0);
        in_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_out_offset", 64'(out_offset), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // reg1+reg2+rel, no wrap
        out_ready = 1'b1;
        push(20'h10035, 16'h0035, 1'b1, 1'b0, 1'b0);
        send(3'd5, 16'h1000, 16'h0, 16'h0005, 16'h0010, 16'h0020, 8'd0, 1'b0);
        @(negedge clk);
        check("m5_latency_valid", 64'(out_valid), 64'd1);
        step();

        // reg1+rel with offset wrap and address carry
        push(20'h00000, 16'h0010, 1'b1, 1'b1, 1'b1);
        send(3'd3, 16'hFFFF, 16'h0, 16'h0020, 16'hFFF0, 16'h0, 8'd0, 1'b0);
        @(negedge clk);
        check("m3_latency_valid", 64'(out_valid), 64'd1);
        step();

        // burst with count 0 behaves as a single beat
        push(20'h00500, 16'h0500, 1'b1, 1'b0, 1'b0);
        send(3'd7, 16'h0000, 16'h0, 16'h0, 16'h0500, 16'h0, 8'd0, 1'b0);
        step();
        @(negedge clk);
        check("cnt0_single_beat", 64'(out_valid), 64'd0);
        step();

        // increment burst crossing the offset boundary, with backpressure on beat 2
        push(20'h2FFFE, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        push(20'h2FFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        push(20'h20000, 16'h0000, 1'b1, 1'b1, 1'b0);
        send(3'd7, 16'h2000, 16'h0, 16'h0, 16'hFFFE, 16'h0, 8'd3, 1'b0);
        @(negedge clk);
        check("burst_b1_in_ready", 64'(in_ready), 64'd0);
        step();
        out_ready = 1'b0;
        set_req(3'd0, 16'h0, 16'h7777, 16'h0, 16'h0, 16'h0, 8'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_out_addr", 64'(out_addr), 64'h2FFFF);
            check("hold_out_offset", 64'(out_offset), 64'hFFFF);
            check("hold_out_last", 64'(out_last), 64'd0);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("burst_b2_in_ready", 64'(in_ready), 64'd0);
        step();
        @(negedge clk);
        check("burst_b3_in_ready", 64'(in_ready), 64'd0);
        step();
        @(negedge clk);
        check("burst_done_valid", 64'(out_valid), 64'd0);
        check("burst_done_in_ready", 64'(in_ready), 64'd1);
        step();

        // decrement burst aborted on beat 2 while a request is offered
        push(20'h01040, 16'h0040, 1'b0, 1'b0, 1'b0);
        send(3'd7, 16'h0100, 16'h0, 16'h0, 16'h0040, 16'h0, 8'd4, 1'b1);
        step();
        abort = 1'b1;
        set_req(3'd2, 16'h0000, 16'h0, 16'h0, 16'h0555, 16'h0, 8'd0, 1'b0);
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        check("abort_beat2_addr", 64'(out_addr), 64'h0103F);
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_abort_valid", 64'(out_valid), 64'd0);
        check("post_abort_in_ready", 64'(in_ready), 64'd1);
        step();
        push(20'h01ABC, 16'h0ABC, 1'b1, 1'b0, 1'b0);
        send(3'd2, 16'h0100, 16'h0, 16'h0, 16'h0ABC, 16'h0, 8'd0, 1'b0);
        @(negedge clk);
        check("post_abort_latency", 64'(out_valid), 64'd1);
        step();

        // reset in the middle of a burst
        push(20'h30000, 16'h0000, 1'b0, 1'b0, 1'b0);
        send(3'd7, 16'h3000, 16'h0, 16'h0, 16'h0000, 16'h0, 8'd5, 1'b0);
        step();
        out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_addr", 64'(out_addr), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(20'h01234, 16'h1234, 1'b1, 1'b0, 1'b0);
        send(3'd0, 16'h0000, 16'h1234, 16'h0, 16'h0, 16'h0, 8'd0, 1'b0);
        @(negedge clk);
        check("postrst_latency", 64'(out_valid), 64'd1);
        step();

        // back-to-back modes 0,1,2 at full rate
        push(20'h00200, 16'h0100, 1'b1, 1'b0, 1'b0);
        set_req(3'd0, 16'h0010, 16'h0100, 16'h0, 16'h0, 16'h0, 8'd0, 1'b0);
        @(negedge clk);
        check("b2b_rdy0", 64'(in_ready), 64'd1);
        step();
        push(20'h08000, 16'h8000, 1'b1, 1'b0, 1'b0);
        set_req(3'd1, 16'h0000, 16'h0, 16'h8000, 16'h0, 16'h0, 8'd0, 1'b0);
        @(negedge clk);
        check("b2b_rdy1", 64'(in_ready), 64'd1);
        check("b2b_valid0", 64'(out_valid), 64'd1);
        step();
        push(20'hFFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        set_req(3'd2, 16'hF000, 16'h0, 16'h0, 16'hFFFF, 16'h0, 8'd0, 1'b0);
        @(negedge clk);
        check("b2b_valid1", 64'(out_valid), 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid2", 64'(out_valid), 64'd1);
        step();
        @(negedge clk);
        check("b2b_drained", 64'(out_valid), 64'd0);
        step();

        // one-cycle drop of out_ready between two requests
        push(20'h00001, 16'h0001, 1'b1, 1'b1, 1'b0);
        set_req(3'd4, 16'h0000, 16'h0, 16'h0, 16'h8000, 16'h8001, 8'd0, 1'b0);
        @(negedge clk);
        check("drop_rdy_first", 64'(in_ready), 64'd1);
        step();
        push(20'h00FFF, 16'h0FFF, 1'b1, 1'b1, 1'b0);
        set_req(3'd6, 16'h0000, 16'h1000, 16'hFFFF, 16'h0, 16'h0, 8'd0, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        check("drop_in_ready", 64'(in_ready), 64'd0);
        check("drop_hold_addr", 64'(out_addr), 64'h00001);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("drop_resume_rdy", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("drop_second_valid", 64'(out_valid), 64'd1);
        step();
        @(negedge clk);
        check("drop_drained", 64'(out_valid), 64'd0);
        step();

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
